// File: rtl/stack_unit.sv
// Operand stack (LIFO) for the stack-machine controller.
// Ports: clk, rst (async low), push/pop/top/din in; dout/dvalid/count/empty/full/ovf/unf out.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             top,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic [PW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_IX = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      sp;
  logic [PW-1:0]    tos_ix;
  logic [PW-1:0]    wr_ix;
  logic             rd_en;
  logic             wr_en;
  logic             inc;
  logic             dec;
  logic             ovf_set;
  logic             unf_set;

  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == FULL_CNT);

  // At sp == DEPTH the low bits wrap to 0, so tos_ix is DEPTH-1.
  assign tos_ix = sp[PW-1:0] - ONE_IX;

  always_comb begin
    rd_en   = (pop | top) & ~empty;
    // push+pop on a non-empty stack overwrites TOS in place.
    wr_en   = push & (pop | ~full);
    wr_ix   = (pop & ~empty) ? tos_ix : sp[PW-1:0];
    inc     = push & ~full & (~pop | empty);
    dec     = pop & ~push & ~empty;
    ovf_set = push & ~pop & full;
    unf_set = (pop | top) & empty;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ix] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp     <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      dvalid <= rd_en;
      if (rd_en) dout <= mem[tos_ix];
      unique case (1'b1)
        inc:     sp <= sp + ONE_CNT;
        dec:     sp <= sp - ONE_CNT;
        default: sp <= sp;
      endcase
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: expected read data queued at issue,
// checked by a monitor whenever dvalid is seen; state checked directly.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       top = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dvalid;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       ovf;
  logic       unf;

  int checks = 0;
  int failures = 0;
  logic [7:0] expq [$];

  stack_unit #(.WIDTH(8), .DEPTH(8), .PW(3)) dut (
    .clk(clk), .rst(rst),
    .push(push), .pop(pop), .top(top),
    .din(din), .dout(dout), .dvalid(dvalid),
    .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dvalid) begin
      if (expq.size() == 0) begin
        chk("unexpected_dvalid", 1, 0);
      end else begin
        chk("dout_sb", dout, expq.pop_front());
      end
    end
  end

  task automatic cyc(input logic p, input logic po, input logic t,
                     input logic [7:0] d,
                     input logic rd, input logic [7:0] e);
    if (rd) expq.push_back(e);
    push = p; pop = po; top = t; din = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; top = 1'b0; din = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ovf", ovf, 0);
    chk("post_rst_unf", unf, 0);

    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 8'(i * 8'h11), 0, 0);
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    chk("fill_ovf", ovf, 0);
    cyc(1, 0, 0, 8'h99, 0, 0);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 8);
    cyc(0, 1, 0, 0, 1, 8'h88);
    chk("pop_after_ovf_count", count, 7);
    cyc(1, 0, 0, 8'h88, 0, 0);

    for (int i = 8; i >= 1; i--) begin
      cyc(0, 1, 0, 0, 1, 8'(i * 8'h11));
      chk("drain_dvalid", dvalid, 1);
    end
    chk("drain_empty", empty, 1);
    chk("drain_unf_clear", unf, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("unf_set", unf, 1);
    chk("unf_dvalid", dvalid, 0);
    chk("unf_dout_hold", dout, 8'h11);
    chk("unf_count", count, 0);

    cyc(1, 0, 0, 8'h3C, 0, 0);
    cyc(0, 0, 1, 0, 1, 8'h3C);
    cyc(0, 0, 1, 0, 1, 8'h3C);
    chk("top_count", count, 1);
    cyc(0, 1, 0, 0, 1, 8'h3C);
    chk("top_pop_count", count, 0);

    cyc(1, 0, 0, 8'h05, 0, 0);
    cyc(1, 0, 0, 8'h0A, 0, 0);
    cyc(1, 1, 0, 8'hF0, 1, 8'h0A);
    chk("replace_count", count, 2);
    cyc(0, 1, 0, 0, 1, 8'hF0);
    cyc(0, 1, 0, 0, 1, 8'h05);
    chk("replace_empty", empty, 1);

    cyc(1, 0, 0, 8'h21, 0, 0);
    cyc(1, 0, 1, 8'h42, 1, 8'h21);
    chk("pushtop_count", count, 2);
    cyc(0, 0, 1, 0, 1, 8'h42);

    cyc(1, 0, 0, 8'hA1, 0, 0);
    cyc(1, 0, 0, 8'hA2, 0, 0);
    cyc(1, 0, 0, 8'hA3, 0, 0);
    chk("pre_arst_count", count, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_dout", dout, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_unf", unf, 0);
    chk("arst_empty", empty, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1, 0, 0, 0, 0);
    chk("post_arst_unf", unf, 1);
    chk("post_arst_dvalid", dvalid, 0);

    cyc(1, 1, 0, 8'h77, 0, 0);
    chk("pushpop_empty_count", count, 1);
    chk("pushpop_empty_dvalid", dvalid, 0);
    cyc(1, 0, 0, 8'h66, 0, 0);
    cyc(0, 1, 1, 0, 1, 8'h66);
    chk("poptop_count", count, 1);
    cyc(0, 1, 0, 0, 1, 8'h77);
    chk("final_empty", empty, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
